// File: rtl/phv_pkg.sv
// phv_pkg: shared PHV beat geometry and the stored beat record.
package phv_pkg;
  localparam int PHV_BYTES = 128;
  localparam int BEAT_W = 1024;
  localparam int OUT_W = 512;
  typedef struct packed {
    logic last;
    logic [BEAT_W-1:0] data;
  } beat_t;
  typedef enum logic {LO = 1'b0, HI = 1'b1} phase_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with registered count; read data is the combinational head entry.
module sync_fifo #(
  parameter int W = 1025,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clock)
    if (wr_en) mem[wp] <= wr_data;
  always_ff @(posedge clock) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end
  assign rd_data = mem[rp];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/out_serializer.sv
// out_serializer: buffers 1024-bit beats and emits them as two 512-bit halves (LO then HI).
// Optional OUT_SERIALIZER_DROP_CNT_EN adds a saturating dropped-beat counter.
module out_serializer #(
  parameter int DEPTH = 4,
  parameter int OUT_W = 512
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2*OUT_W-1:0] io_in_data,
  input  logic              io_in_en,
  input  logic              io_in_last,
  output logic [OUT_W-1:0]  io_out_data,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic              io_out_last,
  output logic              io_overflow,
  output logic [31:0]       io_drop_cnt
);
  import phv_pkg::*;
  localparam int CW = $clog2(DEPTH + 1);
  phase_t phase, phase_nx;
  beat_t head;
  logic full, empty, hs, pop, wr, drop;
  logic [CW-1:0] count;
  sync_fifo #(.W(BEAT_W + 1), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .wr_en(wr),
    .wr_data({io_in_last, io_in_data}),
    .rd_en(pop),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // a full FIFO still accepts a beat when the final half leaves in the same cycle
  assign hs = io_out_valid & io_out_ready;
  assign pop = hs & (phase == HI);
  assign wr = io_in_en & (~full | pop);
  assign drop = io_in_en & full & ~pop;
  always_ff @(posedge clock)
    phase <= reset ? LO : phase_nx;
  always_comb begin
    phase_nx = phase;
    if (hs) phase_nx = (phase == LO) ? HI : LO;
  end
  assign io_out_valid = ~empty;
  assign io_out_data = (phase == HI) ? head.data[2*OUT_W-1:OUT_W] : head.data[OUT_W-1:0];
  assign io_out_last = (phase == HI) & head.last & (count != '0);
  always_ff @(posedge clock)
    if (reset) io_overflow <= 1'b0;
    else if (drop) io_overflow <= 1'b1;
`ifdef OUT_SERIALIZER_DROP_CNT_EN
  logic [31:0] drop_cnt;
  always_ff @(posedge clock)
    if (reset) drop_cnt <= '0;
    else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
  assign io_drop_cnt = drop_cnt;
`else
  assign io_drop_cnt = '0;
`endif
endmodule

// File: tb/tb_out_serializer.sv
// tb_out_serializer: directed table, reset sequence and randomized run against a queue model.
module tb_out_serializer;
  localparam int DEPTH = 4;
`ifdef OUT_SERIALIZER_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1;
  logic [1023:0] in_data = '0;
  logic in_en = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [511:0] out_data;
  logic out_valid, out_last, overflow;
  logic [31:0] drop_cnt;
  int errors = 0, checks = 0;
  out_serializer #(.DEPTH(DEPTH), .OUT_W(512)) dut (
    .clock(clock),
    .reset(reset),
    .io_in_data(in_data),
    .io_in_en(in_en),
    .io_in_last(in_last),
    .io_out_data(out_data),
    .io_out_valid(out_valid),
    .io_out_ready(out_ready),
    .io_out_last(out_last),
    .io_overflow(overflow),
    .io_drop_cnt(drop_cnt)
  );
  always #5 clock = ~clock;
  typedef struct {
    bit en, lst, rdy;
    int tag;
    bit v, hi;
    int dtag;
    bit xl, ovf;
    int unsigned drop;
  } vec_t;
  vec_t tbl[$];
  logic [1024:0] q[$];
  bit ph, movf;
  int unsigned mdrop;
  function automatic logic [1023:0] pat(int tag);
    logic [1023:0] d;
    for (int k = 0; k < 128; k++) d[8*k +: 8] = 8'(k + 3 * tag);
    return d;
  endfunction
  function automatic logic [511:0] half(logic [1023:0] d, bit hi);
    return hi ? d[1023:512] : d[511:0];
  endfunction
  task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic model_step();
    bit v, hs;
    v = q.size() != 0;
    hs = v && out_ready;
    if (reset) begin
      q.delete();
      ph = 0;
      movf = 0;
      mdrop = 0;
    end else begin
      if (hs && ph) void'(q.pop_front());
      if (hs) ph = !ph;
      if (in_en) begin
        if (q.size() < DEPTH) q.push_back({in_last, in_data});
        else begin
          movf = 1;
          if (mdrop != 32'hFFFF_FFFF) mdrop++;
        end
      end
    end
  endtask
  task automatic tick(bit en, bit lst, logic [1023:0] d, bit rdy);
    in_en = en;
    in_last = lst;
    in_data = d;
    out_ready = rdy;
    model_step();
    @(posedge clock);
    #1;
  endtask
  task automatic r(bit en, bit lst, bit rdy, int tag, bit v, bit hi, int dtag, bit xl, bit ovf, int unsigned drop);
    tbl.push_back('{en, lst, rdy, tag, v, hi, dtag, xl, ovf, drop});
  endtask
  task automatic chk_model(string nm);
    chk({nm, "_valid"}, 512'(out_valid), 512'(q.size() != 0));
    if (q.size() != 0) begin
      chk({nm, "_data"}, out_data, half(q[0][1023:0], ph));
      chk({nm, "_last"}, 512'(out_last), 512'(ph && q[0][1024]));
    end
    chk({nm, "_ovf"}, 512'(overflow), 512'(movf));
    chk({nm, "_drop"}, 512'(drop_cnt), 512'(CNT_EN ? mdrop : 0));
  endtask
  initial begin
    logic [1023:0] rd;
    repeat (2) tick(0, 0, '0, 0);
    reset = 1'b0;
    chk("rst_valid", 512'(out_valid), 512'(0));
    chk("rst_last", 512'(out_last), 512'(0));
    chk("rst_ovf", 512'(overflow), 512'(0));
    chk("rst_drop", 512'(drop_cnt), 512'(0));
    r(1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    r(0, 0, 1, 0, 1, 1, 0, 1, 0, 0);
    r(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    r(1, 1, 1, 1, 1, 0, 1, 0, 0, 0);
    r(0, 0, 1, 0, 1, 1, 1, 1, 0, 0);
    repeat (5) r(0, 0, 0, 0, 1, 1, 1, 1, 0, 0);
    r(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int t = 2; t <= 5; t++) r(1, 1, 0, t, 1, 0, 2, 0, 0, 0);
    r(1, 1, 0, 6, 1, 0, 2, 0, 1, 1);
    for (int t = 2; t <= 5; t++) begin
      r(0, 0, 1, 0, 1, 1, t, 1, 1, 1);
      if (t < 5) r(0, 0, 1, 0, 1, 0, t + 1, 0, 1, 1);
    end
    r(0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    for (int t = 7; t <= 10; t++) r(1, 1, 0, t, 1, 0, 7, 0, 1, 1);
    r(0, 0, 1, 0, 1, 1, 7, 1, 1, 1);
    r(1, 1, 1, 11, 1, 0, 8, 0, 1, 1);
    for (int t = 8; t <= 11; t++) begin
      r(0, 0, 1, 0, 1, 1, t, 1, 1, 1);
      if (t < 11) r(0, 0, 1, 0, 1, 0, t + 1, 0, 1, 1);
    end
    r(0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    foreach (tbl[i]) begin
      tick(tbl[i].en, tbl[i].lst, pat(tbl[i].tag), tbl[i].rdy);
      chk($sformatf("row%0d_valid", i), 512'(out_valid), 512'(tbl[i].v));
      if (tbl[i].v) begin
        chk($sformatf("row%0d_data", i), out_data, half(pat(tbl[i].dtag), tbl[i].hi));
        chk($sformatf("row%0d_last", i), 512'(out_last), 512'(tbl[i].xl));
      end
      chk($sformatf("row%0d_ovf", i), 512'(overflow), 512'(tbl[i].ovf));
      chk($sformatf("row%0d_drop", i), 512'(drop_cnt), 512'(CNT_EN ? tbl[i].drop : 0));
    end
    tick(1, 0, pat(12), 0);
    tick(1, 1, pat(13), 0);
    tick(0, 0, '0, 1);
    chk("mid_hi_data", out_data, half(pat(12), 1));
    chk("mid_hi_last", 512'(out_last), 512'(0));
    reset = 1'b1;
    tick(1, 1, pat(15), 1);
    reset = 1'b0;
    chk("mid_rst_valid", 512'(out_valid), 512'(0));
    chk("mid_rst_last", 512'(out_last), 512'(0));
    chk("mid_rst_ovf", 512'(overflow), 512'(0));
    chk("mid_rst_drop", 512'(drop_cnt), 512'(0));
    tick(1, 1, pat(14), 1);
    chk("post_lo_data", out_data, half(pat(14), 0));
    chk("post_lo_last", 512'(out_last), 512'(0));
    tick(0, 0, '0, 1);
    chk("post_hi_data", out_data, half(pat(14), 1));
    chk("post_hi_last", 512'(out_last), 512'(1));
    tick(0, 0, '0, 1);
    chk("post_empty", 512'(out_valid), 512'(0));
    for (int c = 0; c < 3000; c++) begin
      for (int w = 0; w < 32; w++) rd[32*w +: 32] = $urandom;
      tick($urandom_range(0, 9) < 6, 1'($urandom), rd, $urandom_range(0, 9) < 5);
      chk_model("rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/out_serializer.md
OUT_SERIALIZER -- requirements
Module: out_serializer

Interface
REQ-001 Parameter DEPTH, default 4: number of 1024-bit beat entries in the buffer; power of two, at least 2.
REQ-002 Parameter OUT_W, default 512: output bus width in bits; fixed ratio 1024/OUT_W = 2 halves per beat.
REQ-003 Port clock  in  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1: synchronous, active-high reset.
REQ-005 Port io_in_data  in  1024: packed PHV beat; byte k occupies bits [8k+7:8k].
REQ-006 Port io_in_en  in  1: beat valid; there is no ready, so the upstream cannot be stalled.
REQ-007 Port io_in_last  in  1: beat is the final beat of its packet.
REQ-008 Port io_out_data  out  512: output half-beat.
REQ-009 Port io_out_valid  out  1: io_out_data is valid.
REQ-010 Port io_out_ready  in  1: downstream accepts the transfer.
REQ-011 Port io_out_last  out  1: final half of the final beat of a packet.
REQ-012 Port io_overflow  out  1: sticky flag set when an input beat is dropped.
REQ-013 Port io_drop_cnt  out  32: count of dropped beats.

Function
REQ-014 A beat SHALL be written to the FIFO in the cycle io_in_en=1 if the FIFO is not full, or if it is full and a final-half pop occurs in the same cycle.
REQ-015 When io_in_en=1, the FIFO is full and no final-half pop occurs, the beat SHALL be discarded, io_overflow set and io_drop_cnt incremented; stored entries SHALL be unaffected.
REQ-016 Output phase FSM: state LO emits head bits [511:0]; state HI emits head bits [1023:512].
REQ-017 The FSM SHALL move LO->HI on a handshake (valid&ready) in LO, and HI->LO on a handshake in HI; the HI handshake SHALL pop the head entry.
REQ-018 io_out_valid SHALL equal FIFO non-empty; io_out_data and io_out_last SHALL be combinational from the head entry and the phase.
REQ-019 io_out_last SHALL be 1 only in state HI when the head entry's last bit is 1.
REQ-020 While io_out_valid=1 and io_out_ready=0, io_out_data and io_out_last SHALL hold stable.
REQ-021 Latency: a beat written at edge N into an empty FIFO SHALL present its LO half with io_out_valid=1 in cycle N+1.
REQ-022 Sustained throughput SHALL be 1 beat per 2 cycles with io_out_ready held at 1; input beats arriving at a faster rate fill the FIFO.
REQ-023 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by a count of DEPTH+1 states.
REQ-024 io_drop_cnt SHALL saturate at 0xFFFFFFFF.
REQ-025 Simultaneous write and pop with the FIFO empty is impossible, because pop requires valid; a write into an empty FIFO is not bypassed.

Reset
REQ-026 Reset SHALL empty the FIFO, set the phase to LO, clear io_overflow and io_drop_cnt; io_out_valid and io_out_last SHALL be 0 in the cycle after reset is sampled.
REQ-027 Reset mid-packet or mid-beat SHALL discard all buffered data, including a half already transferred; io_in_en is ignored while reset=1.

Configuration
REQ-028 Macro OUT_SERIALIZER_DROP_CNT_EN defined: io_drop_cnt SHALL be implemented per REQ-015 and REQ-024.
REQ-029 Macro OUT_SERIALIZER_DROP_CNT_EN undefined: the counter register SHALL be absent and io_drop_cnt tied to 0; io_overflow SHALL be unchanged.

Structure
REQ-030 Shared package phv_pkg SHALL hold PHV_BYTES=128, BEAT_W=1024, OUT_W=512, and the beat typedef {last, data[1023:0]}.
REQ-031 Storage SHALL be a sub-module sync_fifo (width BEAT_W+1, depth DEPTH, with full/empty/count); the phase FSM and overflow logic SHALL reside in out_serializer.

Verification
REQ-032 Single beat, data byte k=k, last=1, ready=1 -> cycle N+1: data bytes 0..63, last=0; cycle N+2: bytes 64..127, last=1; then valid=0.
REQ-033 Backpressure: ready=0 for 5 cycles during HI -> data and last stay stable; after ready rises, exactly 1 pop occurs and there is no duplicate output.
REQ-034 Overflow: ready=0, 5 consecutive beats with DEPTH=4 -> 4 stored, io_overflow=1, io_drop_cnt=1; drain yields beats 1-4 in order.
REQ-035 Full with io_in_en coinciding with a HI pop -> beat accepted, no drop, count stays 4.
REQ-036 Reset asserted after the LO half of a 2-beat packet -> next cycle valid=0, phase LO, counters 0; a new beat streams correctly.
REQ-037 Build without OUT_SERIALIZER_DROP_CNT_EN, overflow scenario -> io_overflow=1, io_drop_cnt=0.
